glip_dii_deframer: RTL and testbench

Host-ingress deframing stage directly upstream of the debug interconnect inside the MPSoC top level. It consumes the raw 16-bit GLIP word stream arriving on the `c_glip_in` channel and emits debug-interconnect (`dii_flit`) packets with correct `last` marking.

The GLIP stream carries length-prefixed frames: one header word N, followed by N payload words. The block strips the header, forwards the payload through a small elastic FIFO, and discards malformed frames while raising error pulses.

---
 rtl/glip_dii_deframer.sv | 148 ++++++++++++++
 tb/tb_glip_dii_deframer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glip_dii_deframer.sv
// glip_dii_deframer
// Strips the length header from the incoming GLIP word stream and forwards
// payload words as DII flits, marking the final flit of each frame with last.
// Zero-length frames and frames longer than MAX_LEN raise one-cycle error
// pulses. Oversize frames are consumed and discarded.

module glip_dii_deframer #(
    parameter int WIDTH      = 16,
    parameter int MAX_LEN    = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glip_in_data,
    input  logic             glip_in_valid,
    output logic             glip_in_ready,
    output logic [WIDTH-1:0] dii_out_data,
    output logic             dii_out_last,
    output logic             dii_out_valid,
    input  logic             dii_out_ready,
    output logic             err_len_zero,
    output logic             err_len_over
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] remain;
    logic [WIDTH-1:0] remain_next;

    // Each entry holds {last, data}
    logic [WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    logic             full;
    logic             empty;
    logic             accept;
    logic             rem_one;
    logic             push;
    logic             pop;
    logic             zero_hit;
    logic             over_hit;

    // The extra pointer MSB separates the full case from the empty case
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign accept  = glip_in_valid && glip_in_ready;
    assign rem_one = (remain == WIDTH'(1));
    assign pop     = dii_out_valid && dii_out_ready;

    // Next-state, counter update, input ready and FIFO push decision
    always_comb begin
        state_next    = state;
        remain_next   = remain;
        glip_in_ready = 1'b1;
        push          = 1'b0;
        zero_hit      = 1'b0;
        over_hit      = 1'b0;
        case (state)
            HDR: begin
                if (accept) begin
                    if (glip_in_data == '0) begin
                        zero_hit = 1'b1;
                    end else if (glip_in_data > WIDTH'(MAX_LEN)) begin
                        over_hit    = 1'b1;
                        remain_next = glip_in_data;
                        state_next  = DROP;
                    end else begin
                        remain_next = glip_in_data;
                        state_next  = PAY;
                    end
                end
            end
            PAY: begin
                glip_in_ready = !full;
                if (accept) begin
                    push        = 1'b1;
                    remain_next = remain - 1'b1;
                    if (rem_one) begin
                        state_next = HDR;
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    remain_next = remain - 1'b1;
                    if (rem_one) begin
                        state_next = HDR;
                    end
                end
            end
            default: begin
                state_next = HDR;
            end
        endcase
    end

    // State, length counter and registered error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HDR;
            remain       <= '0;
            err_len_zero <= 1'b0;
            err_len_over <= 1'b0;
        end else begin
            state        <= state_next;
            remain       <= remain_next;
            err_len_zero <= zero_hit;
            err_len_over <= over_hit;
        end
    end

    // FIFO pointers; reset abandons any buffered flits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; last is set on the word that takes remain from 1 to 0
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {rem_one, glip_in_data};
        end
    end

    // Output side reads the head entry; zeros are shown while empty
    assign dii_out_valid = !empty;
    assign {dii_out_last, dii_out_data} = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_glip_dii_deframer.sv
// Testbench for glip_dii_deframer: directed frames plus a random frame stream,
// checked against a queue of expected flits filled as frames are sent.

module tb_glip_dii_deframer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] glip_in_data = '0;
    logic        glip_in_valid = 1'b0;
    logic        glip_in_ready;
    logic [15:0] dii_out_data;
    logic        dii_out_last;
    logic        dii_out_valid;
    logic        dii_out_ready = 1'b0;
    logic        err_len_zero;
    logic        err_len_over;

    int checks = 0;
    int errors = 0;
    int zero_obs = 0;
    int over_obs = 0;
    int zero_exp = 0;
    int over_exp = 0;
    bit rand_mode = 1'b0;

    logic [16:0] exp_q [$];

    glip_dii_deframer #(
        .WIDTH(16),
        .MAX_LEN(12),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .glip_in_data(glip_in_data),
        .glip_in_valid(glip_in_valid),
        .glip_in_ready(glip_in_ready),
        .dii_out_data(dii_out_data),
        .dii_out_last(dii_out_last),
        .dii_out_valid(dii_out_valid),
        .dii_out_ready(dii_out_ready),
        .err_len_zero(err_len_zero),
        .err_len_over(err_len_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] w, input logic last);
        exp_q.push_back({last, w});
    endtask

    // One clock: monitor at the falling edge, then return 1 time unit after the rising edge
    task automatic cycle(output logic acc);
        logic [16:0] exp_f;
        @(negedge clk);
        acc = glip_in_valid && glip_in_ready;
        if (!rst) begin
            if (err_len_zero) zero_obs++;
            if (err_len_over) over_obs++;
            if (dii_out_valid && dii_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_flit", 32'(dii_out_valid), 32'd0);
                end else begin
                    exp_f = exp_q.pop_front();
                    check("flit", {15'd0, dii_out_last, dii_out_data}, {15'd0, exp_f});
                end
            end
        end
        @(posedge clk);
        #1;
        if (rand_mode) dii_out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic step();
        logic a;
        cycle(a);
    endtask

    task automatic send_word(input logic [15:0] w);
        logic acc;
        int n;
        if (rand_mode) begin
            while ($urandom_range(0, 3) == 0) begin
                glip_in_valid = 1'b0;
                step();
            end
        end
        glip_in_valid = 1'b1;
        glip_in_data  = w;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 500) begin
            cycle(acc);
            n++;
        end
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input int len);
        logic [15:0] w;
        bit legal;
        legal = (len >= 1) && (len <= 12);
        if (len == 0) zero_exp++;
        if (len > 12) over_exp++;
        send_word(16'(len));
        for (int i = 0; i < len; i++) begin
            w = 16'($urandom);
            if (legal) push_exp(w, i == len - 1);
            send_word(w);
        end
    endtask

    task automatic drain();
        int n;
        glip_in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) step();
    endtask

    initial begin
        int err_base;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(glip_in_ready), 32'd1);
        check("rst_out_valid", 32'(dii_out_valid), 32'd0);
        check("rst_out_data", 32'(dii_out_data), 32'd0);
        check("rst_out_last", 32'(dii_out_last), 32'd0);
        check("rst_err", {30'd0, err_len_zero, err_len_over}, 32'd0);
        step();
        step();
        rst = 1'b0;
        dii_out_ready = 1'b1;
        step();

        // Single packet with one-cycle latency
        err_base = zero_obs + over_obs;
        send_word(16'd3);
        push_exp(16'hA001, 1'b0);
        push_exp(16'hA002, 1'b0);
        push_exp(16'hA003, 1'b1);
        send_word(16'hA001);
        check("t1_latency_valid", 32'(dii_out_valid), 32'd1);
        check("t1_latency_data", 32'(dii_out_data), 32'hA001);
        send_word(16'hA002);
        send_word(16'hA003);
        drain();
        check("t1_no_err", 32'(zero_obs + over_obs), 32'(err_base));

        // Backpressure
        dii_out_ready = 1'b0;
        send_word(16'd6);
        for (int i = 1; i <= 6; i++) push_exp(16'hD000 + 16'(i), i == 6);
        for (int i = 1; i <= 4; i++) send_word(16'hD000 + 16'(i));
        check("t2_full_ready", 32'(glip_in_ready), 32'd0);
        glip_in_valid = 1'b0;
        repeat (6) step();
        check("t2_hold_ready", 32'(glip_in_ready), 32'd0);
        check("t2_hold_valid", 32'(dii_out_valid), 32'd1);
        check("t2_hold_data", 32'(dii_out_data), 32'hD001);
        dii_out_ready = 1'b1;
        send_word(16'hD005);
        send_word(16'hD006);
        drain();

        // Zero length header
        err_base = zero_obs;
        zero_exp++;
        send_word(16'd0);
        check("t3_zero_pulse", 32'(err_len_zero), 32'd1);
        send_word(16'd1);
        push_exp(16'hB001, 1'b1);
        send_word(16'hB001);
        drain();
        check("t3_zero_count", 32'(zero_obs), 32'(err_base + 1));

        // Oversize header
        err_base = over_obs;
        over_exp++;
        send_word(16'd13);
        check("t4_over_pulse", 32'(err_len_over), 32'd1);
        for (int i = 0; i < 13; i++) send_word(16'hEE00 + 16'(i));
        send_word(16'd2);
        push_exp(16'hC001, 1'b0);
        push_exp(16'hC002, 1'b1);
        send_word(16'hC001);
        send_word(16'hC002);
        drain();
        check("t4_over_count", 32'(over_obs), 32'(err_base + 1));

        // Reset mid-frame
        dii_out_ready = 1'b0;
        send_word(16'd5);
        send_word(16'hE001);
        send_word(16'hE002);
        glip_in_valid = 1'b0;
        check("t5_pre_valid", 32'(dii_out_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(dii_out_valid), 32'd0);
        check("t5_rst_in_ready", 32'(glip_in_ready), 32'd1);
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        dii_out_ready = 1'b1;
        send_word(16'd1);
        push_exp(16'hF001, 1'b1);
        send_word(16'hF001);
        drain();

        // Random stream
        rand_mode = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            send_frame($urandom_range(0, 15));
        end
        drain();
        rand_mode = 1'b0;
        check("err_zero_total", 32'(zero_obs), 32'(zero_exp));
        check("err_over_total", 32'(over_obs), 32'(over_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
